// File: rtl/mdu_iter.sv
// mdu_iter -- iterative multiply/divide unit with HI/LO registers.
//
// Executes the MIPS R-type operations that the single-cycle ALU cannot:
// mult, multu, div, divu (one shift-add / restoring shift-subtract step per
// cycle, WIDTH steps plus one finishing cycle) and mthi/mtlo (single-edge
// register writes). Operands are latched when a request is accepted, so the
// execute stage may change them freely while busy is high.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   funct  in   MIPS funct field selecting the operation
//   a      in   rs operand (multiplicand / dividend / mthi-mtlo source)
//   b      in   rt operand (multiplier / divisor)
//   busy   out  operation in progress, new start ignored
//   done   out  one-cycle pulse, HI/LO just updated
//   dz     out  one-cycle pulse with done on divide by zero
//   hi     out  HI register
//   lo     out  LO register
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    // acc_hi: partial product high half / partial remainder / raw dividend on divide by zero
    // acc_lo: multiplier shifting out, product low half shifting in / dividend out, quotient in
    logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic              neg_q, neg_d;        // negate product / quotient at FIN
    logic              rneg_q, rneg_d;      // negate remainder at FIN
    logic              is_div_q, is_div_d;
    logic              dzp_q, dzp_d;        // divide by zero pending in FIN
    logic              done_q, done_d;
    logic              dzo_q, dzo_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               last_step;

    // Magnitude of the most negative value wraps to itself, which read as
    // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the WIDTH+1 bit sum and the multiplier right together.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

    // Restoring step: the shifted remainder is below 2*divisor, so bit WIDTH
    // of the difference is a clean borrow indicator.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];

    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_fix = neg_q  ? -prod     : prod;
    assign quo_fix  = neg_q  ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = rneg_q ? -acc_hi_q : acc_hi_q;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        dzp_d    = dzp_q;
        done_d   = 1'b0;
        dzo_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (funct)
                        F_MULT, F_MULTU: begin
                            acc_hi_d = '0;
                            acc_lo_d = (funct == F_MULT) ? b_mag : b;
                            opnd_d   = (funct == F_MULT) ? a_mag : a;
                            neg_d    = (funct == F_MULT) && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d   = 1'b0;
                            is_div_d = 1'b0;
                            dzp_d    = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        F_DIV, F_DIVU: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (b == '0) begin
                                // Keep the raw dividend; FIN copies it to HI.
                                acc_hi_d = a;
                                dzp_d    = 1'b1;
                                neg_d    = 1'b0;
                                rneg_d   = 1'b0;
                                state_d  = S_FIN;
                            end else begin
                                acc_hi_d = '0;
                                acc_lo_d = (funct == F_DIV) ? a_mag : a;
                                opnd_d   = (funct == F_DIV) ? b_mag : b;
                                neg_d    = (funct == F_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                                rneg_d   = (funct == F_DIV) && a[WIDTH-1];
                                dzp_d    = 1'b0;
                                state_d  = S_DIV;
                            end
                        end
                        F_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        F_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end
            end
            S_DIV: begin
                acc_hi_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    cnt_d   = '0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                dzp_d   = 1'b0;
                if (dzp_q) begin
                    hi_d  = acc_hi_q;
                    lo_d  = '1;
                    dzo_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            dzp_q    <= 1'b0;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            dzp_q    <= dzp_d;
            done_q   <= done_d;
            dzo_q    <= dzo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dzo_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter (WIDTH=32). Expected HI/LO/dz/latency come from a
// behavioural model built on native 64-bit arithmetic and are queued when an
// operation is issued, then popped when the unit reports done.
module tb_mdu_iter;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t         scb[$];
    logic [W-1:0] m_hi, m_lo;
    int           n_cmp  = 0;
    int           n_fail = 0;

    // Behavioural model: updates the model HI/LO and queues what the DUT
    // must show when it reports done. Undecoded funct queues nothing.
    task automatic model_push(input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        logic [W-1:0] uq, ur;
        e.dz  = 1'b0;
        e.lat = W + 1;
        sa  = longint'($signed(aa));
        sbv = longint'($signed(bb));
        case (f)
            F_MULT: begin
                p = 64'(sa * sbv);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_MULTU: begin
                p = {32'b0, aa} * {32'b0, bb};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            F_DIV, F_DIVU: begin
                if (bb == 0) begin
                    m_lo  = '1;
                    m_hi  = aa;
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else if (f == F_DIV) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    uq = aa / bb;
                    ur = aa % bb;
                    m_lo = uq;
                    m_hi = ur;
                end
            end
            F_MTHI: begin
                m_hi  = aa;
                e.lat = 0;
            end
            F_MTLO: begin
                m_lo  = aa;
                e.lat = 0;
            end
            default: return;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        scb.push_back(e);
    endtask

    // Issue one request, scramble the operand inputs after acceptance and
    // wait (bounded) for done. lat counts edges after the accept edge;
    // lat = -1 means done never came.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output int lat, output int bcnt, output logic [W-1:0] ohi,
                         output logic [W-1:0] olo, output logic odz, output logic odn);
        @(negedge clk);
        start = 1'b1; funct = f; a = aa; b = bb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; funct = 6'($urandom); a = $urandom; b = $urandom;
        lat = 0; bcnt = 0;
        forever begin
            if (busy) bcnt++;
            if (done) break;
            if (lat >= 100) begin lat = -1; break; end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        ohi = hi; olo = lo; odz = dz;
        @(negedge clk);
        odn = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; funct = '0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (dz !== 1'b0)   begin n_fail++; $display("FAIL reset_dz got=%b want=0", dz); end
        n_cmp++; if (hi !== '0)     begin n_fail++; $display("FAIL reset_hi got=%h want=0", hi); end
        n_cmp++; if (lo !== '0)     begin n_fail++; $display("FAIL reset_lo got=%h want=0", lo); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    // Runs a table of operations, each compared against the scoreboard.
    task automatic run_table(input string tag, input logic [5:0] fs[], input logic [W-1:0] as[],
                             input logic [W-1:0] bs[]);
        int lat, bc; logic [W-1:0] oh, ol; logic odz, odn; exp_t e;
        for (int i = 0; i < fs.size(); i++) begin
            model_push(fs[i], as[i], bs[i]);
            do_op(fs[i], as[i], bs[i], lat, bc, oh, ol, odz, odn);
            e = scb.pop_front();
            $display("%s[%0d] f=%b a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy=%0d",
                     tag, i, fs[i], as[i], bs[i], oh, ol, odz, lat, bc);
            n_cmp++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s[%0d]_latency got=%0d want=%0d", tag, i, lat, e.lat); end
            n_cmp++; if (bc !== e.lat)  begin n_fail++; $display("FAIL %s[%0d]_busy_cycles got=%0d want=%0d", tag, i, bc, e.lat); end
            n_cmp++; if (oh !== e.hi)   begin n_fail++; $display("FAIL %s[%0d]_hi got=%h want=%h", tag, i, oh, e.hi); end
            n_cmp++; if (ol !== e.lo)   begin n_fail++; $display("FAIL %s[%0d]_lo got=%h want=%h", tag, i, ol, e.lo); end
            n_cmp++; if (odz !== e.dz)  begin n_fail++; $display("FAIL %s[%0d]_dz got=%b want=%b", tag, i, odz, e.dz); end
            n_cmp++; if (odn !== 1'b0)  begin n_fail++; $display("FAIL %s[%0d]_done_width got=%b want=0", tag, i, odn); end
        end
    endtask

    task automatic test_mul();
        logic [5:0]   fs[] = '{F_MULT, F_MULTU, F_MULT, F_MULT, F_MULTU};
        logic [W-1:0] as[] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0};
        logic [W-1:0] bs[] = '{32'h7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
        run_table("mul", fs, as, bs);
    endtask

    task automatic test_div();
        logic [5:0]   fs[] = '{F_DIV, F_DIVU, F_DIV, F_DIVU, F_DIVU, F_DIV, F_DIV};
        logic [W-1:0] as[] = '{32'hFFFFFFF9, 32'h7, 32'h80000000, 32'h5, 32'h9, 32'hFFFFFFF7, 32'h7};
        logic [W-1:0] bs[] = '{32'h2, 32'h2, 32'hFFFFFFFF, 32'h0, 32'h3, 32'h0, 32'hFFFFFFFE};
        run_table("div", fs, as, bs);
    endtask

    task automatic test_random();
        logic [5:0]   fs[] = new[10];
        logic [W-1:0] as[] = new[10];
        logic [W-1:0] bs[] = new[10];
        logic [5:0]   ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        for (int i = 0; i < 10; i++) begin
            fs[i] = ops[$urandom_range(0, 3)];
            as[i] = $urandom;
            bs[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
        end
        run_table("rnd", fs, as, bs);
    endtask

    task automatic test_busy_reset();
        int cyc; logic seen; exp_t e;
        // mult 3x4 with an ignored div request in the middle
        model_push(F_MULT, 32'd3, 32'd4);
        @(negedge clk); start = 1'b1; funct = F_MULT; a = 32'd3; b = 32'd4;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; funct = F_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk); start = 1'b0;
        cyc = 5;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        e = scb.pop_front();
        $display("busy_ignore: hi=%h lo=%h lat=%0d", hi, lo, cyc);
        n_cmp++; if (cyc !== e.lat) begin n_fail++; $display("FAIL busy_ignore_latency got=%0d want=%0d", cyc, e.lat); end
        n_cmp++; if (hi !== e.hi)   begin n_fail++; $display("FAIL busy_ignore_hi got=%h want=%h", hi, e.hi); end
        n_cmp++; if (lo !== e.lo)   begin n_fail++; $display("FAIL busy_ignore_lo got=%h want=%h", lo, e.lo); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle got=%b want=0", busy); end

        // second mult aborted by reset at iteration 10
        @(negedge clk); start = 1'b1; funct = F_MULT; a = 32'd5; b = 32'd6;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("reset_mid_op: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_cmp++; if (hi !== '0)     begin n_fail++; $display("FAIL abort_hi got=%h want=0", hi); end
        n_cmp++; if (lo !== '0)     begin n_fail++; $display("FAIL abort_lo got=%h want=0", lo); end
        m_hi = '0; m_lo = '0;
        scb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b want=0", seen); end
    endtask

    task automatic test_after_reset();
        logic [5:0]   fs[] = '{F_MULT};
        logic [W-1:0] as[] = '{32'd3};
        logic [W-1:0] bs[] = '{32'd4};
        run_table("post_rst", fs, as, bs);
    endtask

    task automatic test_move();
        logic [5:0]   fs[] = '{F_MTHI, F_MTLO};
        logic [W-1:0] as[] = '{32'h1234, 32'h55};
        logic [W-1:0] bs[] = '{32'h0, 32'h0};
        run_table("move", fs, as, bs);
    endtask

    task automatic test_undecoded();
        logic seen;
        @(negedge clk); start = 1'b1; funct = 6'b100000; a = 32'hDEAD; b = 32'hBEEF;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done || busy) seen = 1'b1;
            @(negedge clk);
        end
        $display("undecoded: hi=%h lo=%h", hi, lo);
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL undecoded_activity got=%b want=0", seen); end
        n_cmp++; if (hi !== m_hi)   begin n_fail++; $display("FAIL undecoded_hi got=%h want=%h", hi, m_hi); end
        n_cmp++; if (lo !== m_lo)   begin n_fail++; $display("FAIL undecoded_lo got=%h want=%h", lo, m_lo); end
    endtask

    task automatic test_back_to_back();
        int cyc; exp_t e;
        model_push(F_MULTU, 32'd2, 32'd3);
        model_push(F_MTLO, 32'h99, 32'h0);
        @(negedge clk); start = 1'b1; funct = F_MULTU; a = 32'd2; b = 32'd3;
        @(posedge clk); @(negedge clk);
        funct = F_MTLO; a = 32'h99;      // start stays high; ignored while busy
        cyc = 0;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        e = scb.pop_front();
        $display("b2b_mul: hi=%h lo=%h lat=%0d", hi, lo, cyc);
        n_cmp++; if (cyc !== e.lat) begin n_fail++; $display("FAIL b2b_mul_latency got=%0d want=%0d", cyc, e.lat); end
        n_cmp++; if (hi !== e.hi)   begin n_fail++; $display("FAIL b2b_mul_hi got=%h want=%h", hi, e.hi); end
        n_cmp++; if (lo !== e.lo)   begin n_fail++; $display("FAIL b2b_mul_lo got=%h want=%h", lo, e.lo); end
        @(negedge clk);
        start = 1'b0;
        e = scb.pop_front();
        $display("b2b_mtlo: done=%b hi=%h lo=%h", done, hi, lo);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_mtlo_done got=%b want=1", done); end
        n_cmp++; if (lo !== e.lo)   begin n_fail++; $display("FAIL b2b_mtlo_lo got=%h want=%h", lo, e.lo); end
        n_cmp++; if (hi !== e.hi)   begin n_fail++; $display("FAIL b2b_mtlo_hi got=%h want=%h", hi, e.hi); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_mtlo_busy got=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_busy_reset();
        test_after_reset();
        test_move();
        test_undecoded();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog simulation did not complete, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit with HI/LO registers, parametrised in datapath width. It extends the ALU control path to the MIPS R-type funct codes the single-cycle ALU cannot execute: mult, multu, div, divu, mthi and mtlo. It sits beside the ALU in the execute stage. The control unit raises `start` with `funct` and operands and stalls the pipeline on `busy`.

## Interface
- `WIDTH`, default 32, operand and HI/LO width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  request; sampled only while idle.
- `funct`  in  6  MIPS funct field selecting the operation.
- `a`  in  WIDTH  operand rs (dividend / multiplicand / mthi-mtlo source).
- `b`  in  WIDTH  operand rt (divisor / multiplier).
- `busy`  out  1  operation in progress; new `start` ignored.
- `done`  out  1  one-cycle pulse: HI/LO just updated.
- `dz`  out  1  one-cycle pulse coincident with `done` for divide by zero.
- `hi`  out  WIDTH  HI register (mfhi reads this directly).
- `lo`  out  WIDTH  LO register (mflo reads this directly).

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, `done`=0, `dz`=0, state IDLE, iteration counter 0.
- Decoded funct values:
  - 011000 mult
  - 011001 multu
  - 011010 div
  - 011011 divu
  - 010001 mthi
  - 010011 mtlo
  - Any other funct with `start`: no action, no `done`.
- States:
  - IDLE: on accepted mult/multu, go to MUL. On div/divu with `b`≠0, go to DIV. On div/divu with `b`=0, go to FIN. On mthi/mtlo, write `hi` or `lo` from `a` at the accept edge and stay IDLE.
  - MUL: one shift-add step per cycle.
  - DIV: one restoring shift-subtract step per cycle.
  - MUL and DIV both go to FIN after exactly WIDTH steps.
  - FIN: apply sign correction, write `hi`/`lo`, return to IDLE.
- Signed ops (mult, div):
  - At accept, latch the magnitudes of `a`/`b` and their sign bits.
  - Product negated if sign(a)^sign(b).
  - Quotient negated if sign(a)^sign(b); remainder takes sign(a).
  - Negation is two's complement modulo 2^(2·WIDTH) for the product and 2^WIDTH for quotient/remainder.
- Unsigned ops use operands as-is.
- Results: mult/multu give `hi`:`lo` = full 2·WIDTH product. div/divu give `lo` = quotient, `hi` = remainder.
- Overflow case: most-negative / −1 (signed) gives `lo` = 2^(WIDTH−1), `hi` = 0, with no flag.
- Divide by zero (both signed and unsigned): `lo` = all ones, `hi` = `a` as latched, `dz`=1 with `done`.
- Operands are latched at accept. Changes on `a`/`b`/`funct` while busy have no effect.
- `hi`/`lo` hold their values except at FIN or an mthi/mtlo accept edge.

## Timing
- Accept edge E0: rising edge with state IDLE and `start`=1.
- mult/multu/div/divu with nonzero divisor:
  - `busy`=1 from E0 through edge E(WIDTH+1).
  - `hi`/`lo` update and `done`=1 at E(WIDTH+1).
  - `done` is high for exactly one cycle.
  - Latency: WIDTH+1 cycles.
- Divide by zero: `busy` for 1 cycle; `hi`/`lo`/`done`/`dz` update at E1.
- mthi/mtlo: register written at E0, `done`=1 for the following cycle, `busy` stays 0.
- Back-to-back: `start` held during the `done` cycle is accepted at that edge (state already IDLE), so there are zero bubble cycles.
- Reset while busy: all outputs return to reset values immediately (asynchronous). The operation is discarded, with no `done`. The first `start` after `rst_n` rises behaves as from reset.

## Test plan
- Signed multiply: WIDTH=32, mult a=0xFFFFFFFD (−3), b=7 → `done` 33 cycles after accept, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `busy` high exactly 33 cycles.
- Unsigned multiply: multu a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Divide: div a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then divu 7/2 → `lo`=3, `hi`=1. Then div 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: divu a=5, b=0 → `done`,`dz` pulse at E1, `lo`=0xFFFFFFFF, `hi`=5. Following divu 9/3 → `dz`=0, `lo`=3, `hi`=0.
- Busy and reset: start mult 3×4, then pulse `start` with div and changed operands mid-operation → ignored, result `hi`=0, `lo`=12. Then assert `rst_n`=0 at iteration 10 of a second mult → `hi`=`lo`=0, `busy`=0 immediately, no `done`.
- Move and back-to-back: mthi a=0x1234 → `hi`=0x1234 next cycle, `busy` never 1. Then mtlo a=0x55 → `lo`=0x55. Then start multu 2×3 held into its `done` cycle with funct mtlo, a=0x99 → `lo`=0x99 one cycle after `done`.
